seg8_scan_ctrl: RTL

SEG8_SCAN_CTRL -- requirements
Module: seg8_scan_ctrl

---
 rtl/seg8_scan_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seg8_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with brightness PWM,
// anti-ghost gaps and frame-synchronous double-buffered updates.
//
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   en               : scan enable (low -> idle, blank)
//   seg_in[63:0]     : active-low segment codes, byte i -> digit i
//   digit_en[7:0]    : per-digit enable mask
//   bright[2:0]      : on-time (bright+1)/8 of each digit slot
//   load             : capture seg_in/digit_en/bright into pending set
//   seg[7:0]         : active-low segment drive (registered)
//   an[7:0]          : active-low digit select (registered)
//   frame_done       : one-cycle pulse at each frame wrap
//   pending          : captured load not yet shown
module seg8_scan_ctrl #(
  parameter int DIV_CYC = 50000,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [63:0] seg_in,
  input  logic [7:0]  digit_en,
  input  logic [2:0]  bright,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int MAXC = (DIV_CYC > GAP_CYC) ? DIV_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  // one eighth of a slot; a constant shift, no divider
  localparam logic [CW:0]   SLICE    = (CW+1)'(DIV_CYC >> 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [63:0] pseg_q, pseg_d;
  logic [7:0]  pmask_q, pmask_d;
  logic [2:0]  plvl_q, plvl_d;
  logic        pend_q, pend_d;

  logic [63:0] disp_q, disp_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  lvl_q, lvl_d;

  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        fd_q, fd_d;

  logic        bnd;
  logic        wrap;
  logic        lit;
  logic [CW:0] on_cyc;

  // scan FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bnd     = 1'b0;
    wrap    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          idx_d   = 3'd0;
          cnt_d   = '0;
          bnd     = 1'b1;
        end
        S_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_SHOW;
            idx_d   = idx_q + 3'd1;
            cnt_d   = '0;
            wrap    = (idx_q == 3'd7);
            bnd     = wrap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // double buffer: a load in a boundary cycle bypasses pending
  always_comb begin
    pseg_d  = pseg_q;
    pmask_d = pmask_q;
    plvl_d  = plvl_q;
    pend_d  = pend_q;
    disp_d  = disp_q;
    mask_d  = mask_q;
    lvl_d   = lvl_q;
    if (load) begin
      pseg_d  = seg_in;
      pmask_d = digit_en;
      plvl_d  = bright;
      pend_d  = 1'b1;
    end
    if (bnd) begin
      if (load) begin
        disp_d = seg_in;
        mask_d = digit_en;
        lvl_d  = bright;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = pseg_q;
        mask_d = pmask_q;
        lvl_d  = plvl_q;
        pend_d = 1'b0;
      end
    end
  end

  // outputs from registers only, one cycle behind state/cnt
  always_comb begin
    on_cyc = (CW+1)'({1'b0, lvl_q} + 4'd1) * SLICE;
    lit    = (state_q == S_SHOW) &&
             ({1'b0, cnt_q} < on_cyc) &&
             mask_q[idx_q];
    an_d   = 8'hFF;
    seg_d  = 8'hFF;
    if (lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = disp_q[8*idx_q +: 8];
    end
    fd_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      pseg_q  <= '1;
      pmask_q <= 8'h00;
      plvl_q  <= 3'd7;
      pend_q  <= 1'b0;
      disp_q  <= '1;
      mask_q  <= 8'h00;
      lvl_q   <= 3'd7;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pseg_q  <= pseg_d;
      pmask_q <= pmask_d;
      plvl_q  <= plvl_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      mask_q  <= mask_d;
      lvl_q   <= lvl_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule
